// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
//  Module      : pipe_hazard_ctrl_pkg
//  Description : Shared encodings for the pipeline hazard/resource scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_hazard_ctrl_pkg;

    // Operand source selects driven towards the ID-stage operand muxes
    localparam logic [1:0] FWD_REG     = 2'b00;
    localparam logic [1:0] FWD_EXALU   = 2'b01;
    localparam logic [1:0] FWD_MEMALU  = 2'b10;
    localparam logic [1:0] FWD_MEMDATA = 2'b11;

    localparam logic [0:0] MS_IDLE = 1'b0;
    localparam logic [0:0] MS_BUSY = 1'b1;

endpackage

`default_nettype wire

// File: rtl/pipe_fwd_sel.sv
// ============================================================================
//  Module      : pipe_fwd_sel
//  Description : Forwarding source selector for a single ID-stage operand.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_src,
    input  logic       i_ewreg,
    input  logic       i_em2reg,
    input  logic [4:0] i_ern,
    input  logic       i_mwreg,
    input  logic       i_mm2reg,
    input  logic [4:0] i_mrn,
    output logic [1:0] o_sel
);

    always_comb begin
        o_sel = FWD_REG;
        // A load in EX has no data yet; that case is covered by the load-use stall
        if (i_src != 5'd0) begin
            if (i_ewreg && !i_em2reg && (i_ern == i_src)) begin
                o_sel = FWD_EXALU;
            end else if (i_mwreg && (i_mrn == i_src)) begin
                o_sel = i_mm2reg ? FWD_MEMDATA : FWD_MEMALU;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Forwarding, load-use stall, multi-cycle multiplier sequencing
//                and stall-cycle counting for the 5-stage pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES  = 4,
    parameter int CNT_W       = 4,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4:0]             rs,
    input  logic [4:0]             rt,
    input  logic                   users,
    input  logic                   usert,
    input  logic                   ewreg,
    input  logic                   em2reg,
    input  logic [4:0]             ern,
    input  logic                   emul,
    input  logic                   mwreg,
    input  logic                   mm2reg,
    input  logic [4:0]             mrn,
    output logic [1:0]             fwda,
    output logic [1:0]             fwdb,
    output logic                   wpcir,
    output logic                   idex_bubble,
    output logic                   idex_hold,
    output logic                   exmem_bubble,
    output logic                   mul_start,
    output logic                   mul_done,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic             c_multi    = (MUL_CYCLES > 1);
    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'((MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0);

    logic [0:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic [1:0] w_fwda;
    logic [1:0] w_fwdb;
    logic       w_idle;
    logic       w_cnt_zero;
    logic       w_ex_hold;
    logic       w_lu;

    pipe_fwd_sel u_fwd_rs (
        .i_src    (rs),
        .i_ewreg  (ewreg),
        .i_em2reg (em2reg),
        .i_ern    (ern),
        .i_mwreg  (mwreg),
        .i_mm2reg (mm2reg),
        .i_mrn    (mrn),
        .o_sel    (w_fwda)
    );

    pipe_fwd_sel u_fwd_rt (
        .i_src    (rt),
        .i_ewreg  (ewreg),
        .i_em2reg (em2reg),
        .i_ern    (ern),
        .i_mwreg  (mwreg),
        .i_mm2reg (mm2reg),
        .i_mrn    (mrn),
        .o_sel    (w_fwdb)
    );

    assign w_idle     = (r_state == MS_IDLE);
    assign w_cnt_zero = (r_cnt == '0);
    assign w_ex_hold  = (w_idle & emul & c_multi) | (~w_idle & ~w_cnt_zero);
    assign w_lu       = ewreg & em2reg & (ern != 5'd0) &
                        ((users & (ern == rs)) | (usert & (ern == rt)));

    // Reset forces every control to its inactive value, independent of inputs
    assign fwda         = reset ? FWD_REG : w_fwda;
    assign fwdb         = reset ? FWD_REG : w_fwdb;
    assign wpcir        = reset | ~(w_ex_hold | w_lu);
    assign idex_hold    = ~reset & w_ex_hold;
    assign exmem_bubble = ~reset & w_ex_hold;
    assign idex_bubble  = ~reset & ~w_ex_hold & w_lu;
    assign mul_start    = ~reset & w_idle & emul;
    assign mul_done     = ~reset & ((~w_idle & w_cnt_zero) | (w_idle & emul & ~c_multi));
    assign stall_cnt    = r_stall_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= MS_IDLE;
            r_cnt   <= '0;
        end else if (w_idle) begin
            if (emul && c_multi) begin
                r_state <= MS_BUSY;
                r_cnt   <= c_cnt_init;
            end
        end else if (w_cnt_zero) begin
            r_state <= MS_IDLE;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (!wpcir && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Self-checking bench for pipe_hazard_ctrl (default build plus
//                a 4-bit stall counter build sharing the same stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam int MC = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] rs, rt, ern, mrn;
    logic       users, usert, ewreg, em2reg, emul, mwreg, mm2reg;

    logic [1:0]  fwda, fwdb;
    logic        wpcir, idex_bubble, idex_hold, exmem_bubble, mul_start, mul_done;
    logic [31:0] stall_cnt;

    logic [1:0]  s_fwda, s_fwdb;
    logic        s_wpcir, s_idex_bubble, s_idex_hold, s_exmem_bubble, s_mul_start, s_mul_done;
    logic [3:0]  s_stall_cnt;

    int     checks = 0;
    int     errors = 0;
    int     m_age  = -1;   // index of the current cycle of a mul in EX, -1 when none
    longint m_stall  = 0;
    int     m_stall4 = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl dut (
        .clock(clock), .reset(reset), .rs(rs), .rt(rt), .users(users), .usert(usert),
        .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .emul(emul), .mwreg(mwreg),
        .mm2reg(mm2reg), .mrn(mrn), .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir),
        .idex_bubble(idex_bubble), .idex_hold(idex_hold), .exmem_bubble(exmem_bubble),
        .mul_start(mul_start), .mul_done(mul_done), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.STALL_CNT_W(4)) dut_sat (
        .clock(clock), .reset(reset), .rs(rs), .rt(rt), .users(users), .usert(usert),
        .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .emul(emul), .mwreg(mwreg),
        .mm2reg(mm2reg), .mrn(mrn), .fwda(s_fwda), .fwdb(s_fwdb), .wpcir(s_wpcir),
        .idex_bubble(s_idex_bubble), .idex_hold(s_idex_hold), .exmem_bubble(s_exmem_bubble),
        .mul_start(s_mul_start), .mul_done(s_mul_done), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] x);
        if (x == 5'd0) return 2'b00;
        if (ewreg && !em2reg && ern == x) return 2'b01;
        if (mwreg && mrn == x) return mm2reg ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    task automatic clr();
        rs = 0; rt = 0; ern = 0; mrn = 0;
        users = 0; usert = 0; ewreg = 0; em2reg = 0; emul = 0; mwreg = 0; mm2reg = 0;
    endtask

    // Called 1 time unit after a rising edge; checks mid-cycle and advances the model.
    task automatic step(input string tag);
        int   cur;
        logic hold, start, done, lu, e_wp;
        @(negedge clock);
        cur   = (m_age >= 0) ? m_age : (emul ? 0 : -1);
        hold  = (cur >= 0) && (cur < MC - 1);
        start = (m_age < 0) && emul;
        done  = (cur == MC - 1);
        lu    = ewreg && em2reg && (ern != 0) && ((users && ern == rs) || (usert && ern == rt));
        e_wp  = !(hold || lu);
        chk({tag, ".fwda"},         32'(fwda),         32'(exp_fwd(rs)));
        chk({tag, ".fwdb"},         32'(fwdb),         32'(exp_fwd(rt)));
        chk({tag, ".wpcir"},        32'(wpcir),        32'(e_wp));
        chk({tag, ".idex_bubble"},  32'(idex_bubble),  32'(lu && !hold));
        chk({tag, ".idex_hold"},    32'(idex_hold),    32'(hold));
        chk({tag, ".exmem_bubble"}, 32'(exmem_bubble), 32'(hold));
        chk({tag, ".mul_start"},    32'(mul_start),    32'(start));
        chk({tag, ".mul_done"},     32'(mul_done),     32'(done));
        chk({tag, ".stall_cnt"},    stall_cnt,         32'(m_stall));
        chk({tag, ".sat_wpcir"},    32'(s_wpcir),      32'(e_wp));
        chk({tag, ".sat_stall"},    32'(s_stall_cnt),  32'(m_stall4));
        @(posedge clock);
        m_age = hold ? cur + 1 : -1;
        if (!e_wp) begin
            m_stall++;
            if (m_stall4 < 15) m_stall4++;
        end
        #1;
    endtask

    initial begin
        logic [3:0] mul_start_pat, mul_done_pat, mul_wp_pat;
        mul_start_pat = 4'b0001;
        mul_done_pat  = 4'b1000;
        mul_wp_pat    = 4'b1000;

        // Reset with hazardous inputs present: everything must read inactive
        reset = 1'b1;
        clr();
        emul = 1; ewreg = 1; em2reg = 1; ern = 7; rs = 7; users = 1; mwreg = 1; mrn = 7;
        #2;
        chk("reset.fwda",      32'(fwda),      32'd0);
        chk("reset.wpcir",     32'(wpcir),     32'd1);
        chk("reset.mul_start", 32'(mul_start), 32'd0);
        chk("reset.idex_bub",  32'(idex_bubble), 32'd0);
        chk("reset.stall_cnt", stall_cnt,      32'd0);
        clr();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // EX beats MEM for the same register
        ewreg = 1; ern = 5; rs = 5; mwreg = 1; mrn = 5;
        #1 chk("ex_wins.fwda", 32'(fwda), 32'd1);
        step("ex_wins");
        rs = 0; ern = 0; mrn = 0;
        #1 chk("r0.fwda", 32'(fwda), 32'd0);
        step("r0");
        clr(); mwreg = 1; mm2reg = 1; mrn = 3; rt = 3;
        #1 chk("memdata.fwdb", 32'(fwdb), 32'd3);
        step("memdata");

        // Load-use on rt, then same without the rt read
        clr(); ewreg = 1; em2reg = 1; ern = 7; rt = 7; usert = 1;
        #1 chk("lu.wpcir", 32'(wpcir), 32'd0);
        step("lu");
        usert = 0;
        #1 chk("nolu.wpcir", 32'(wpcir), 32'd1);
        step("nolu");

        // Plain 4-cycle multiply
        clr(); emul = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("mul%0d.start", i), 32'(mul_start), 32'(mul_start_pat[i]));
            chk($sformatf("mul%0d.done", i),  32'(mul_done),  32'(mul_done_pat[i]));
            chk($sformatf("mul%0d.wpcir", i), 32'(wpcir),     32'(mul_wp_pat[i]));
            step($sformatf("mul%0d", i));
        end
        emul = 0;
        step("mul_gap");

        // Multiply with a pending load-use: hold first, then a single bubble
        ewreg = 1; em2reg = 1; ern = 9; rs = 9; users = 1; emul = 1;
        #1 chk("mullu.idex_bubble", 32'(idex_bubble), 32'd0);
        for (int i = 0; i < 4; i++) step($sformatf("mullu%0d", i));
        clr();
        step("mullu_end");

        // Back-to-back multiplies with emul held high
        emul = 1;
        for (int i = 0; i < 8; i++) step($sformatf("b2b%0d", i));
        emul = 0;
        step("b2b_end");

        // Reset while BUSY with cnt=1
        emul = 1;
        step("rst_mul0");
        step("rst_mul1");
        #1 reset = 1'b1;
        #1;
        chk("midrst.wpcir",     32'(wpcir),     32'd1);
        chk("midrst.idex_hold", 32'(idex_hold), 32'd0);
        chk("midrst.mul_start", 32'(mul_start), 32'd0);
        chk("midrst.mul_done",  32'(mul_done),  32'd0);
        chk("midrst.stall_cnt", stall_cnt,      32'd0);
        emul = 0;
        @(negedge clock);
        reset = 1'b0;
        m_age = -1; m_stall = 0; m_stall4 = 0;
        @(posedge clock);
        #1;
        emul = 1;
        for (int i = 0; i < 4; i++) step($sformatf("fresh%0d", i));
        emul = 0;
        step("fresh_end");

        // Drive the 4-bit counter past its ceiling
        ewreg = 1; em2reg = 1; ern = 4; rs = 4; users = 1;
        for (int i = 0; i < 20; i++) step($sformatf("sat%0d", i));
        chk("sat.hold15", 32'(s_stall_cnt), 32'd15);
        clr();

        // Randomized traffic over a small register range to provoke matches
        for (int i = 0; i < 250; i++) begin
            rs = 5'($urandom_range(0, 3));  rt = 5'($urandom_range(0, 3));
            ern = 5'($urandom_range(0, 3)); mrn = 5'($urandom_range(0, 3));
            users = 1'($urandom); usert = 1'($urandom);
            ewreg = 1'($urandom); em2reg = 1'($urandom);
            mwreg = 1'($urandom); mm2reg = 1'($urandom);
            emul = ($urandom_range(0, 3) == 0);
            step($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
